// File: rtl/dac_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_stream_ctrl_if
//  Description : Sample-stream, DAC-output and status bundle for
//                dac_stream_ctrl. The slave modport is the controller's
//                view; the master modport is the core/host side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_stream_ctrl_if #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
);
  localparam int c_lvl_w = $clog2(DEPTH) + 1;

  logic               enable;
  logic [DIV_W-1:0]   div;
  logic               s_valid;
  logic [DATA_W-1:0]  s_data;
  logic               s_ready;
  logic [DATA_W-1:0]  dac_d;
  logic               dac_strobe;
  logic               underrun;
  logic               clr_underrun;
  logic [c_lvl_w-1:0] level;
  logic [1:0]         state;

  modport master (
    output enable, div, s_valid, s_data, clr_underrun,
    input  s_ready, dac_d, dac_strobe, underrun, level, state
  );

  modport slave (
    input  enable, div, s_valid, s_data, clr_underrun,
    output s_ready, dac_d, dac_strobe, underrun, level, state
  );
endinterface
`default_nettype wire

// File: rtl/dac_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dac_stream_ctrl
//  Description : Buffers core samples in a small FIFO and paces them into
//                the DAC at a programmable period. Streaming starts once the
//                FIFO is primed; an empty FIFO at a sample tick holds the last
//                DAC code, raises a sticky underrun flag and re-primes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_stream_ctrl #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 16,
  parameter int PRIME_LVL = 2,
  parameter int IDLE_CODE = 512
) (
  input wire               CLK,
  input wire               reset,
  dac_stream_ctrl_if.slave bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = $clog2(DEPTH) + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_prime = 2'd1;
  localparam logic [1:0] c_st_run   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [DIV_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic [DATA_W-1:0]  r_dac;
  logic               r_strobe;
  logic               r_underrun;

  logic w_full;
  logic w_empty;
  logic w_primed;
  logic w_tick;
  logic w_push;
  logic w_pop;
  logic w_underrun_set;
  logic w_cnt_clear;
  logic w_cnt_load;
  logic w_cnt_dec;

  // FIFO status is taken from the registered level only, so s_ready never
  // depends on a same-cycle pop.
  assign w_full   = (r_level == c_lvl_w'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_primed = (r_level >= c_lvl_w'(PRIME_LVL));
  assign w_tick   = (r_cnt == '0);
  assign w_push   = bus.s_valid & ~w_full;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; dropping enable returns to IDLE from any state
  always_comb begin
    w_next_state = r_state;
    if (!bus.enable) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:  w_next_state = c_st_prime;
        c_st_prime: if (w_primed) w_next_state = c_st_run;
        c_st_run:   if (w_tick && w_empty) w_next_state = c_st_prime;
        default:    w_next_state = c_st_idle;
      endcase
    end
  end

  // Per-state actions: counter control, pop and underrun detection
  always_comb begin
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    w_cnt_clear    = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    if (!bus.enable) begin
      w_cnt_clear = 1'b1;
    end else begin
      case (r_state)
        c_st_idle:  w_cnt_clear = 1'b1;
        c_st_prime: w_cnt_load  = w_primed;
        c_st_run: begin
          if (!w_tick) begin
            w_cnt_dec = 1'b1;
          end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_cnt_load = 1'b1;
          end else begin
            // Counter stays at zero while re-priming.
            w_underrun_set = 1'b1;
          end
        end
        default: w_cnt_clear = 1'b1;
      endcase
    end
  end

  // Sample-period counter; div is only sampled on reload
  always_ff @(posedge CLK) begin
    if (reset || w_cnt_clear) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= bus.div;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // DAC code register and its one-cycle update strobe
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dac    <= DATA_W'(IDLE_CODE);
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_pop;
      if (w_pop) r_dac <= r_mem[r_rd_ptr];
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (bus.clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign bus.s_ready    = ~w_full;
  assign bus.dac_d      = r_dac;
  assign bus.dac_strobe = r_strobe;
  assign bus.underrun   = r_underrun;
  assign bus.level      = r_level;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_stream_ctrl
//  Description : Self-checking bench for dac_stream_ctrl. A queue-based
//                reference model tracks FIFO contents, sample period and
//                underrun; directed scenarios plus a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_stream_ctrl;

  localparam int DATA_W    = 10;
  localparam int DEPTH     = 4;
  localparam int DIV_W     = 16;
  localparam int PRIME_LVL = 2;
  localparam int IDLE_CODE = 512;
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  dac_stream_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

  dac_stream_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W),
    .PRIME_LVL(PRIME_LVL), .IDLE_CODE(IDLE_CODE)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: FIFO as a queue, period as a countdown to the next tick.
  int m_q[$];
  int m_state = 0;   // 0 IDLE, 1 PRIME, 2 RUN
  int m_cnt = 0;     // cycles remaining before the next tick
  int m_dac = IDLE_CODE;
  bit m_strobe = 1'b0;
  bit m_unf = 1'b0;

  // Advance one clock: evaluate the rules on pre-edge values, then commit.
  task automatic step();
    int ns, nc, nd;
    bit nstb, nunf, take;
    take = bus.s_valid && (m_q.size() < DEPTH);
    ns = m_state; nc = m_cnt; nd = m_dac; nstb = 1'b0; nunf = m_unf;
    if (reset) begin
      m_q.delete();
      ns = 0; nc = 0; nd = IDLE_CODE; nunf = 1'b0;
    end else begin
      if (!bus.enable) begin
        ns = 0; nc = 0;
      end else if (m_state == 0) begin
        ns = 1;
      end else if (m_state == 1) begin
        if (m_q.size() >= PRIME_LVL) begin ns = 2; nc = int'(bus.div); end
      end else if (m_cnt > 0) begin
        nc = m_cnt - 1;
      end else if (m_q.size() > 0) begin
        nd = m_q.pop_front(); nstb = 1'b1; nc = int'(bus.div);
      end else begin
        ns = 1; nunf = 1'b1;
      end
      if (!(ns == 1 && m_state == 2 && bus.enable) && bus.clr_underrun) nunf = 1'b0;
      if (take) m_q.push_back(int'(bus.s_data));
    end
    @(posedge CLK);
    #1;
    cyc++;
    m_state = ns; m_cnt = nc; m_dac = nd; m_strobe = nstb; m_unf = nunf;
  endtask

  task automatic drive(input bit en, input int dv, input bit v, input int d, input bit clr);
    bus.enable = en;
    bus.div = DIV_W'(dv);
    bus.s_valid = v;
    bus.s_data = DATA_W'(d);
    bus.clr_underrun = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    if (bus.dac_d !== DATA_W'(IDLE_CODE)) begin n_errors++; $display("FAIL reset_dac_d: got %0d expected %0d", bus.dac_d, IDLE_CODE); end
    n_checks++;
    if (bus.dac_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_strobe: got %b expected 0", bus.dac_strobe); end
    n_checks++;
    if (bus.level !== LVL_W'(0)) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
    n_checks++;
    if (bus.state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    n_checks++;
    if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun); end
    n_checks++;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int vals[3];
    int when[3];
    int got;
    drive(1, 3, 1, 10, 0); step();
    drive(1, 3, 1, 20, 0); step();
    drive(1, 3, 1, 30, 0); step();
    drive(1, 3, 0, 0, 0);
    if (bus.state !== 2'd2) begin n_errors++; $display("FAIL stream_run_entry: state %0d expected 2", bus.state); end
    n_checks++;
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      step();
      if (bus.dac_strobe === 1'b1) begin vals[got] = int'(bus.dac_d); when[got] = cyc; got++; end
    end
    if (got != 3) begin n_errors++; $display("FAIL stream_strobe_count: got %0d expected 3", got); end
    n_checks++;
    for (int i = 0; i < 3 && i < got; i++) begin
      if (vals[i] != 10 * (i + 1)) begin n_errors++; $display("FAIL stream_value%0d: got %0d expected %0d", i, vals[i], 10 * (i + 1)); end
      n_checks++;
    end
    for (int i = 1; i < got; i++) begin
      if (when[i] - when[i-1] != 4) begin n_errors++; $display("FAIL stream_period%0d: got %0d expected 4", i, when[i] - when[i-1]); end
      n_checks++;
    end
    if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL stream_underrun: got %b expected 0", bus.underrun); end
    n_checks++;
  endtask

  task automatic test_underrun();
    int waited;
    int got;
    int vals[2];
    waited = 0;
    while (bus.underrun !== 1'b1 && waited < 20) begin step(); waited++; end
    if (waited != 4) begin n_errors++; $display("FAIL underrun_latency: got %0d cycles expected 4", waited); end
    n_checks++;
    if (bus.dac_strobe !== 1'b0) begin n_errors++; $display("FAIL underrun_strobe: got %b expected 0", bus.dac_strobe); end
    n_checks++;
    if (bus.state !== 2'd1) begin n_errors++; $display("FAIL underrun_state: got %0d expected 1", bus.state); end
    n_checks++;
    if (bus.dac_d !== DATA_W'(30)) begin n_errors++; $display("FAIL underrun_hold: got %0d expected 30", bus.dac_d); end
    n_checks++;
    drive(1, 3, 1, 40, 0); step();
    drive(1, 3, 1, 50, 0); step();
    drive(1, 3, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      step();
      if (bus.dac_strobe === 1'b1) begin vals[got] = int'(bus.dac_d); got++; end
    end
    if (got != 2 || vals[0] != 40 || vals[1] != 50) begin
      n_errors++; $display("FAIL resume_values: got %0d strobes (%0d,%0d) expected 2 (40,50)", got, vals[0], vals[1]);
    end
    n_checks++;
  endtask

  task automatic test_backpressure();
    int k;
    int got;
    int first;
    int vals[5];
    bit acc;
    drive(0, 0, 0, 0, 0);
    step();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 100 + k, 0);
      acc = bus.s_ready;
      step();
      if (acc) k++;
    end
    if (k != 4) begin n_errors++; $display("FAIL bp_accepted: got %0d expected 4", k); end
    n_checks++;
    if (bus.level !== LVL_W'(4)) begin n_errors++; $display("FAIL bp_level: got %0d expected 4", bus.level); end
    n_checks++;
    if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL bp_s_ready: got %b expected 0", bus.s_ready); end
    n_checks++;
    got = 0; first = 0;
    for (int i = 0; i < 30 && got < 5; i++) begin
      drive(1, 0, (k < 5), 100 + k, 0);
      acc = bus.s_ready && (k < 5);
      step();
      if (acc) k++;
      if (bus.dac_strobe === 1'b1) begin
        if (got == 0) first = cyc;
        vals[got] = int'(bus.dac_d); got++;
      end
    end
    drive(1, 0, 0, 0, 0);
    if (got != 5 || cyc - first != 4) begin n_errors++; $display("FAIL bp_rate: got %0d strobes over %0d cycles expected 5 over 4", got, cyc - first); end
    n_checks++;
    for (int i = 0; i < got; i++) begin
      if (vals[i] != 100 + i) begin n_errors++; $display("FAIL bp_value%0d: got %0d expected %0d", i, vals[i], 100 + i); end
      n_checks++;
    end
  endtask

  task automatic test_disable_mid();
    int waited;
    logic [LVL_W-1:0] lvl;
    drive(1, 3, 0, 0, 1); step();
    drive(1, 3, 1, 200, 0); step();
    drive(1, 3, 1, 201, 0); step();
    drive(1, 3, 1, 202, 0); step();
    drive(1, 3, 0, 0, 0);
    waited = 0;
    while (!(m_state == 2 && m_cnt == 0 && m_q.size() > 0) && waited < 20) begin step(); waited++; end
    if (waited >= 20) begin n_errors++; $display("FAIL dis_wait_tick: got timeout expected pending tick"); end
    n_checks++;
    lvl = bus.level;
    drive(0, 3, 0, 0, 0);
    step();
    if (bus.dac_strobe !== 1'b0) begin n_errors++; $display("FAIL dis_strobe: got %b expected 0", bus.dac_strobe); end
    n_checks++;
    if (bus.state !== 2'd0) begin n_errors++; $display("FAIL dis_state: got %0d expected 0", bus.state); end
    n_checks++;
    if (bus.level !== lvl) begin n_errors++; $display("FAIL dis_level: got %0d expected %0d", bus.level, lvl); end
    n_checks++;
    drive(1, 3, 0, 0, 0);
    step();
    if (bus.state !== 2'd1) begin n_errors++; $display("FAIL reen_prime: got %0d expected 1", bus.state); end
    n_checks++;
    step();
    if (bus.state !== 2'd2) begin n_errors++; $display("FAIL reen_run: got %0d expected 2", bus.state); end
    n_checks++;
  endtask

  task automatic test_flag_race();
    int waited;
    drive(1, 0, 0, 0, 1); step();
    if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL clr_underrun: got %b expected 0", bus.underrun); end
    n_checks++;
    drive(1, 0, 0, 0, 0);
    waited = 0;
    while (!(m_state == 2 && m_cnt == 0 && m_q.size() == 0) && waited < 40) begin step(); waited++; end
    if (waited >= 40) begin n_errors++; $display("FAIL race_wait: got timeout expected empty tick"); end
    n_checks++;
    drive(1, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0);
    if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL race_set_wins: got %b expected 1", bus.underrun); end
    n_checks++;
    drive(1, 0, 1, 300, 0); step();
    drive(1, 0, 1, 301, 0); step();
    drive(1, 0, 1, 302, 0); step();
    drive(1, 0, 1, 303, 0); step();
    if (bus.dac_d === DATA_W'(IDLE_CODE) || bus.level === LVL_W'(0)) begin
      n_errors++; $display("FAIL midreset_setup: dac_d %0d level %0d expected streaming with data", bus.dac_d, bus.level);
    end
    n_checks++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    if (bus.dac_d !== DATA_W'(IDLE_CODE) || bus.level !== LVL_W'(0) || bus.state !== 2'd0) begin
      n_errors++; $display("FAIL midreset: dac_d %0d level %0d state %0d expected 512 0 0", bus.dac_d, bus.level, bus.state);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    int dv;
    dv = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) dv = int'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 15) != 0), dv, ($urandom_range(0, 9) < 4 + (i / 500) % 4),
            int'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0));
      step();
      got = {bus.dac_d, bus.dac_strobe, bus.underrun, bus.level, bus.state, bus.s_ready};
      exp = {DATA_W'(m_dac), m_strobe, m_unf, LVL_W'(m_q.size()), 2'(m_state), (m_q.size() < DEPTH)};
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random cycle %0d {dac,stb,unf,lvl,st,rdy}: got %h expected %h", cyc, got, exp);
      end
      n_checks++;
    end
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_stream();
    test_underrun();
    test_backpressure();
    test_disable_mid();
    test_flag_race();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
